// File: rtl/car_pkg.sv
// Shared detector indices, link-state encoding and received-frame layout
// for the frame receiver.
package car_pkg;

    localparam int unsigned DET_FRONT = 0;
    localparam int unsigned DET_LEFT  = 1;
    localparam int unsigned DET_RIGHT = 2;
    localparam int unsigned DET_BACK  = 3;
    localparam int unsigned NUM_DET   = DET_BACK + 1;

    typedef enum logic {
        LINK_DOWN = 1'b0,
        LINK_UP   = 1'b1
    } link_state_e;

    typedef struct packed {
        logic [1:0]         hdr;
        logic [1:0]         rsvd;
        logic [NUM_DET-1:0] det;
    } frame_t;

    // A fork is open when at least two of front/left/right are clear.
    function automatic logic fork_detect(input logic [NUM_DET-1:0] s);
        return (!s[DET_FRONT] && !s[DET_LEFT])  ||
               (!s[DET_FRONT] && !s[DET_RIGHT]) ||
               (!s[DET_LEFT]  && !s[DET_RIGHT]);
    endfunction

endpackage

// File: rtl/detector_frame_rx_if.sv
// Frame/strobe inputs and conditioned detector outputs of detector_frame_rx.
interface detector_frame_rx_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tick_en;
    logic       hold_clr;
    logic [3:0] det_stable;
    logic [3:0] det_on_long;
    logic [3:0] det_off_long;
    logic       fork_here;
    logic       fork_rise;
    logic       link_ok;
    logic [7:0] hdr_err_cnt;

    modport master (
        output rx_data, rx_valid, tick_en, hold_clr,
        input  det_stable, det_on_long, det_off_long,
               fork_here, fork_rise, link_ok, hdr_err_cnt
    );

    modport slave (
        input  rx_data, rx_valid, tick_en, hold_clr,
        output det_stable, det_on_long, det_off_long,
               fork_here, fork_rise, link_ok, hdr_err_cnt
    );

endinterface

// File: rtl/det_channel.sv
// One detector channel: frame-based debounce of the stable level plus a
// saturating hold timer measuring how long that level has persisted.
module det_channel #(
    parameter int unsigned DEB_FRAMES = 3,
    parameter int unsigned HOLD_TICKS = 50
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic i_frame,
    input  logic i_bit,
    input  logic i_load,
    input  logic i_force,
    input  logic i_tick_en,
    input  logic i_hold_clr,
    output logic o_stable,
    output logic o_held
);

    localparam int unsigned DEB_W  = 4;
    localparam int unsigned HOLD_W = $clog2(HOLD_TICKS + 1);

    logic              r_stable;
    logic              w_stable_nxt;
    logic [DEB_W-1:0]  r_deb;
    logic [DEB_W-1:0]  w_deb_nxt;
    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] w_hold_nxt;

    always_comb begin
        w_stable_nxt = r_stable;
        w_deb_nxt    = r_deb;
        w_hold_nxt   = r_hold;

        if (i_force) begin
            w_stable_nxt = 1'b1;
            w_deb_nxt    = '0;
        end else if (i_load) begin
            w_stable_nxt = i_bit;
            w_deb_nxt    = '0;
        end else if (i_frame) begin
            if (i_bit == r_stable) begin
                w_deb_nxt = '0;
            end else if (r_deb == DEB_W'(DEB_FRAMES - 1)) begin
                w_stable_nxt = i_bit;
                w_deb_nxt    = '0;
            end else begin
                w_deb_nxt = r_deb + DEB_W'(1);
            end
        end

        // Any level change or link transition restarts the hold measurement.
        if (i_force || i_load || i_hold_clr || (w_stable_nxt != r_stable)) begin
            w_hold_nxt = '0;
        end else if (i_tick_en && (r_hold != HOLD_W'(HOLD_TICKS))) begin
            w_hold_nxt = r_hold + HOLD_W'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            r_stable <= 1'b1;
            r_deb    <= '0;
            r_hold   <= '0;
        end else begin
            r_stable <= w_stable_nxt;
            r_deb    <= w_deb_nxt;
            r_hold   <= w_hold_nxt;
        end
    end

    assign o_stable = r_stable;
    assign o_held   = (r_hold == HOLD_W'(HOLD_TICKS));

endmodule

// File: rtl/detector_frame_rx.sv
// Validates UART status frames, tracks link liveness, and produces debounced
// detector levels, hold flags and fork indication for the navigation FSM.
module detector_frame_rx
    import car_pkg::*;
#(
    parameter logic [1:0]  HDR           = 2'b10,
    parameter int unsigned DEB_FRAMES    = 3,
    parameter int unsigned HOLD_TICKS    = 50,
    parameter int unsigned TIMEOUT_TICKS = 25
) (
    input  logic               sys_clk,
    input  logic               rst,
    detector_frame_rx_if.slave bus
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_TICKS + 1);
    localparam int unsigned ERR_W = 8;

    frame_t             w_frame;
    logic               w_good;
    logic               w_bad;
    logic               w_unused;
    link_state_e        r_state;
    link_state_e        w_state_nxt;
    logic               w_load;
    logic               w_force;
    logic               w_deb_frame;
    logic [TMO_W-1:0]   r_tmo;
    logic [TMO_W-1:0]   w_tmo_nxt;
    logic [ERR_W-1:0]   r_err;
    logic               r_fork_d;
    logic               r_fork_rise;
    logic               w_fork_here;
    logic [NUM_DET-1:0] w_stable;
    logic [NUM_DET-1:0] w_held;

    assign w_frame  = frame_t'(bus.rx_data);
    assign w_good   = bus.rx_valid && (w_frame.hdr == HDR);
    assign w_bad    = bus.rx_valid && (w_frame.hdr != HDR);
    assign w_unused = ^w_frame.rsvd;

    always_ff @(posedge sys_clk) begin
        if (!rst) r_state <= LINK_DOWN;
        else      r_state <= w_state_nxt;
    end

    // Link FSM: a good frame in the expiring tick's cycle keeps the link up.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_force     = 1'b0;
        w_deb_frame = 1'b0;
        w_tmo_nxt   = r_tmo;
        case (r_state)
            LINK_DOWN: begin
                if (w_good) begin
                    w_state_nxt = LINK_UP;
                    w_load      = 1'b1;
                    w_tmo_nxt   = '0;
                end
            end
            LINK_UP: begin
                if (w_good) begin
                    w_deb_frame = 1'b1;
                    w_tmo_nxt   = '0;
                end else if (bus.tick_en) begin
                    if (r_tmo == TMO_W'(TIMEOUT_TICKS - 1)) begin
                        w_state_nxt = LINK_DOWN;
                        w_force     = 1'b1;
                        w_tmo_nxt   = '0;
                    end else begin
                        w_tmo_nxt = r_tmo + TMO_W'(1);
                    end
                end
            end
            default: w_state_nxt = LINK_DOWN;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            r_tmo       <= '0;
            r_err       <= '0;
            r_fork_d    <= 1'b0;
            r_fork_rise <= 1'b0;
        end else begin
            r_tmo       <= w_tmo_nxt;
            if (w_bad && (r_err != '1)) r_err <= r_err + ERR_W'(1);
            r_fork_d    <= w_fork_here;
            r_fork_rise <= w_fork_here && !r_fork_d;
        end
    end

    for (genvar g = 0; g < NUM_DET; g++) begin : g_ch
        det_channel #(
            .DEB_FRAMES (DEB_FRAMES),
            .HOLD_TICKS (HOLD_TICKS)
        ) u_ch (
            .sys_clk    (sys_clk),
            .rst        (rst),
            .i_frame    (w_deb_frame),
            .i_bit      (w_frame.det[g]),
            .i_load     (w_load),
            .i_force    (w_force),
            .i_tick_en  (bus.tick_en),
            .i_hold_clr (bus.hold_clr),
            .o_stable   (w_stable[g]),
            .o_held     (w_held[g])
        );
    end

    assign w_fork_here      = fork_detect(w_stable);
    assign bus.det_stable   = w_stable;
    assign bus.det_on_long  = w_stable & w_held;
    assign bus.det_off_long = ~w_stable & w_held;
    assign bus.fork_here    = w_fork_here;
    assign bus.fork_rise    = r_fork_rise;
    assign bus.link_ok      = (r_state == LINK_UP);
    assign bus.hdr_err_cnt  = r_err;

endmodule

// File: tb/tb_detector_frame_rx.sv
// Directed and randomized checks of detector_frame_rx against a
// cycle-level behavioural reference model.
module tb_detector_frame_rx;

    localparam int DEB  = 3;
    localparam int HOLD = 50;
    localparam int TMO  = 25;

    logic sys_clk = 1'b0;
    logic rst     = 1'b0;
    always #5 sys_clk = ~sys_clk;

    detector_frame_rx_if bus ();

    detector_frame_rx #(
        .HDR           (2'b10),
        .DEB_FRAMES    (DEB),
        .HOLD_TICKS    (HOLD),
        .TIMEOUT_TICKS (TMO)
    ) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit         m_up;
    logic [3:0] m_stable;
    int         m_deb  [4];
    int         m_hold [4];
    int         m_tmo;
    int         m_err;
    bit         m_fork_d;
    bit         m_fork_rise;

    function automatic bit fork_of(input logic [3:0] s);
        int z = 0;
        for (int i = 0; i < 3; i++) if (!s[i]) z++;
        return z >= 2;
    endfunction

    task automatic model_clear_counters();
        for (int i = 0; i < 4; i++) begin
            m_deb[i]  = 0;
            m_hold[i] = 0;
        end
        m_tmo = 0;
    endtask

    task automatic model_reset();
        m_up        = 1'b0;
        m_stable    = 4'hF;
        m_err       = 0;
        m_fork_d    = 1'b0;
        m_fork_rise = 1'b0;
        model_clear_counters();
    endtask

    task automatic model_step(input bit r, input bit vld, input logic [7:0] d,
                              input bit tick, input bit clr);
        logic [3:0] old;
        bit good;
        if (!r) begin
            model_reset();
            return;
        end
        good = vld && (d[7:6] == 2'b10);
        if (vld && !good && m_err < 255) m_err++;
        old = m_stable;
        if (!m_up && good) begin
            m_up     = 1'b1;
            m_stable = d[3:0];
            model_clear_counters();
        end else if (m_up && !good && tick && m_tmo == TMO - 1) begin
            m_up     = 1'b0;
            m_stable = 4'hF;
            model_clear_counters();
        end else begin
            if (m_up) begin
                if (good)      m_tmo = 0;
                else if (tick) m_tmo++;
            end
            for (int i = 0; i < 4; i++) begin
                if (m_up && good) begin
                    if (d[i] == m_stable[i]) m_deb[i] = 0;
                    else if (m_deb[i] == DEB - 1) begin
                        m_stable[i] = d[i];
                        m_deb[i]    = 0;
                    end else m_deb[i]++;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (m_stable[i] != old[i] || clr) m_hold[i] = 0;
                else if (tick && m_hold[i] < HOLD) m_hold[i]++;
            end
        end
        m_fork_rise = fork_of(old) && !m_fork_d;
        m_fork_d    = fork_of(old);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [3:0] on_l, off_l;
        for (int i = 0; i < 4; i++) begin
            on_l[i]  = m_stable[i]  && (m_hold[i] == HOLD);
            off_l[i] = !m_stable[i] && (m_hold[i] == HOLD);
        end
        chk("det_stable",   {4'b0, bus.det_stable},   {4'b0, m_stable});
        chk("det_on_long",  {4'b0, bus.det_on_long},  {4'b0, on_l});
        chk("det_off_long", {4'b0, bus.det_off_long}, {4'b0, off_l});
        chk("fork_here",    {7'b0, bus.fork_here},    {7'b0, fork_of(m_stable)});
        chk("fork_rise",    {7'b0, bus.fork_rise},    {7'b0, m_fork_rise});
        chk("link_ok",      {7'b0, bus.link_ok},      {7'b0, m_up});
        chk("hdr_err_cnt",  bus.hdr_err_cnt,          8'(m_err));
    endtask

    task automatic step(input bit vld, input logic [7:0] d, input bit tick, input bit clr);
        bus.rx_valid = vld;
        bus.rx_data  = d;
        bus.tick_en  = tick;
        bus.hold_clr = clr;
        @(posedge sys_clk);
        model_step(rst, vld, d, tick, clr);
        #1;
        check_model();
    endtask

    initial begin
        logic [3:0] pat;
        logic [7:0] d;
        bit         vld, tick, clr;
        int         frame_pct;

        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tick_en  = 1'b0;
        bus.hold_clr = 1'b0;
        model_reset();

        // Reset values
        rst = 1'b0;
        step(0, 8'h00, 0, 0);
        step(1, 8'h83, 1, 0);
        rst = 1'b1;
        step(0, 8'h00, 0, 0);
        chk("rst_stable", {4'b0, bus.det_stable}, 8'h0F);
        chk("rst_link",   {7'b0, bus.link_ok},    8'h00);
        chk("rst_err",    bus.hdr_err_cnt,        8'h00);

        // First good frame loads directly
        step(1, 8'h83, 0, 0);
        chk("load_link",   {7'b0, bus.link_ok},    8'h01);
        chk("load_stable", {4'b0, bus.det_stable}, 8'h03);

        // Debounce needs three consecutive differing frames
        step(1, 8'h80, 0, 0);
        step(1, 8'h80, 0, 0);
        chk("deb_hold2", {4'b0, bus.det_stable}, 8'h03);
        step(1, 8'h83, 0, 0);
        step(1, 8'h80, 0, 0);
        step(1, 8'h80, 0, 0);
        chk("deb_hold_restart", {4'b0, bus.det_stable}, 8'h03);
        step(1, 8'h80, 0, 0);
        chk("deb_flip", {4'b0, bus.det_stable}, 8'h00);
        chk("fork_set", {7'b0, bus.fork_here},  8'h01);
        chk("rise_lag", {7'b0, bus.fork_rise},  8'h00);
        step(0, 8'h00, 0, 0);
        chk("rise_pulse", {7'b0, bus.fork_rise}, 8'h01);
        step(0, 8'h00, 0, 0);
        chk("rise_once", {7'b0, bus.fork_rise}, 8'h00);

        // Hold flag on the 50th tick, cleared by hold_clr
        for (int i = 1; i <= HOLD; i++) begin
            step(1, 8'h80, 1, 0);
            if (i == HOLD - 1) chk("off_long_49", {7'b0, bus.det_off_long[1]}, 8'h00);
        end
        chk("off_long_50", {7'b0, bus.det_off_long[1]}, 8'h01);
        step(0, 8'h00, 0, 1);
        chk("off_long_clr", {7'b0, bus.det_off_long[1]}, 8'h00);

        // Timeout after 25 ticks without a frame
        for (int i = 1; i <= TMO; i++) begin
            step(0, 8'h00, 1, 0);
            if (i == TMO - 1) chk("tmo_24_up", {7'b0, bus.link_ok}, 8'h01);
        end
        chk("tmo_down",   {7'b0, bus.link_ok},    8'h00);
        chk("tmo_forced", {4'b0, bus.det_stable}, 8'h0F);
        chk("tmo_fork",   {7'b0, bus.fork_here},  8'h00);

        // Frame on the expiring tick keeps the link
        step(1, 8'h80, 0, 0);
        for (int i = 1; i < TMO; i++) step(0, 8'h00, 1, 0);
        step(1, 8'h80, 1, 0);
        chk("tmo_frame_wins", {7'b0, bus.link_ok}, 8'h01);
        step(0, 8'h00, 1, 0);
        chk("tmo_restarted", {7'b0, bus.link_ok}, 8'h01);

        // Bad headers saturate the error counter
        for (int i = 0; i < 300; i++) step(1, 8'h43, 0, 0);
        chk("err_sat",        bus.hdr_err_cnt,        8'hFF);
        chk("err_no_effect",  {4'b0, bus.det_stable}, 8'h00);

        // Reset during a debounce run
        step(1, 8'h8F, 0, 0);
        step(1, 8'h8F, 0, 0);
        rst = 1'b0;
        step(1, 8'h80, 1, 0);
        chk("midrst_stable", {4'b0, bus.det_stable}, 8'h0F);
        chk("midrst_link",   {7'b0, bus.link_ok},    8'h00);
        chk("midrst_err",    bus.hdr_err_cnt,        8'h00);
        rst = 1'b1;
        step(1, 8'h85, 0, 0);
        chk("reload_stable", {4'b0, bus.det_stable}, 8'h05);
        chk("reload_link",   {7'b0, bus.link_ok},    8'h01);

        // Randomized traffic: noisy detector pattern, busy and quiet link phases
        pat = 4'($urandom);
        for (int k = 0; k < 4000; k++) begin
            frame_pct = ((k / 500) % 2 == 1) ? 3 : 40;
            if ($urandom_range(0, 99) < 2) pat = 4'($urandom);
            vld  = ($urandom_range(0, 99) < frame_pct);
            tick = ($urandom_range(0, 99) < 25);
            clr  = ($urandom_range(0, 199) == 0);
            d    = {2'b10, 2'($urandom), pat};
            if ($urandom_range(0, 99) < 15) d[$urandom_range(0, 3)] = ~d[$urandom_range(0, 3)];
            if ($urandom_range(0, 99) < 10) d[7:6] = 2'($urandom);
            rst = ($urandom_range(0, 799) != 0);
            step(vld, d, tick, clr);
        end
        rst = 1'b1;
        step(0, 8'h00, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/detector_frame_rx.md
# detector_frame_rx

Sits between the UART receiver and the driving state machine. It validates each received status byte, debounces the four obstacle detectors across frames, measures how long each detector has held its level, and raises a fork indication. Loss of the UART link forces a safe all-blocked view. The result is clean, stable detector inputs for the semi-auto navigation states.

## Interface
Parameters:
- `HDR`, 2'b10: required value of frame bits [7:6].
- `DEB_FRAMES`, 3: consecutive differing frames needed to flip a stable bit (1..15).
- `HOLD_TICKS`, 50: `tick_en` pulses a stable level must persist to assert held flags (50 × 20 ms = 1 s).
- `TIMEOUT_TICKS`, 25: `tick_en` pulses without a good frame before the link drops.

Ports:
- `sys_clk` in 1: system clock, 100 MHz.
- `rst` in 1: reset, synchronous, active-low.
- `rx_data` in 8: received byte. Bit 0 front, 1 left, 2 right, 3 back; [5:4] ignored; [7:6] header.
- `rx_valid` in 1: one-cycle strobe qualifying `rx_data`.
- `tick_en` in 1: one-cycle timebase strobe.
- `hold_clr` in 1: clears all hold counters.
- `det_stable` out 4: debounced detector levels, same bit order as `rx_data`; 1 = obstacle.
- `det_on_long` out 4: per channel, stable = 1 held ≥ `HOLD_TICKS`.
- `det_off_long` out 4: per channel, stable = 0 held ≥ `HOLD_TICKS`.
- `fork_here` out 1: at least two of front/left/right stable = 0.
- `fork_rise` out 1: one-cycle pulse on the 0→1 transition of `fork_here`.
- `link_ok` out 1: link FSM is in LINK_UP.
- `hdr_err_cnt` out 8: count of rejected frames, saturating.

## Operation
- Good frame: `rx_valid` & `rx_data[7:6]==HDR`. Bad header: frame dropped, `hdr_err_cnt`++ (saturates at 255), no other effect.
- Link FSM:
  - LINK_DOWN → LINK_UP on a good frame. `det_stable` loads `rx_data[3:0]` directly, bypassing debounce. Debounce and hold counters clear.
  - LINK_UP → LINK_DOWN when the timeout counter reaches `TIMEOUT_TICKS`. `det_stable` is forced to 4'b1111; debounce and hold counters clear.
  - Timeout counter clears on each good frame and increments on `tick_en` in LINK_UP. A good frame and the expiring tick in the same cycle: the frame wins and the link stays up.
- Per-channel debounce (LINK_UP, good frame):
  - Bit equals stable: `deb_cnt` ← 0.
  - Bit differs and `deb_cnt == DEB_FRAMES-1`: stable ← bit, `deb_cnt` ← 0.
  - Otherwise: `deb_cnt`++.
  - Non-frame cycles leave `deb_cnt` unchanged.
- Per-channel hold counter:
  - Clears when that channel's stable bit changes, or on `hold_clr`. `hold_clr` has priority over `tick_en`.
  - Otherwise increments on `tick_en`, saturating at `HOLD_TICKS`.
  - Held = (counter == `HOLD_TICKS`). `det_on_long` = stable & held; `det_off_long` = ~stable & held.
- `fork_here` is combinational from registered `det_stable`. `fork_rise` is registered.

## Timing
- Reset values: `det_stable` = 4'b1111, `link_ok` = 0, all other outputs and all counters 0, FSM in LINK_DOWN.
- `det_stable` updates on the edge that samples the qualifying frame and is visible the next cycle: 1-cycle latency from `rx_valid`.
- Held flags assert on the edge of the `HOLD_TICKS`-th tick and drop on the same edge as the stable change or `hold_clr`.
- `fork_rise` appears one cycle after `fork_here` rises.
- `rst` low mid-frame or mid-count returns every register to its reset value on that edge. `rx_valid` in that cycle is ignored.

## Structure
- `car_pkg`: detector index constants (`DET_FRONT` = 0, `DET_LEFT` = 1, `DET_RIGHT` = 2, `DET_BACK` = 3) and the link-state encoding (LINK_DOWN = 0, LINK_UP = 1).
- Sub-module `det_channel`, instantiated 4×, holds the debounce counter, stable bit and hold counter. Its ports are frame strobe, bit, load, force, `tick_en`, `hold_clr`, stable, held. The link FSM, header check, error counter and fork logic stay in the top.

## Test plan
- Reset, then good frame 0x83 → next cycle `link_ok` = 1, `det_stable` = 4'b0011, `hdr_err_cnt` = 0.
- LINK_UP with stable 4'b0011; send 0x80 twice, then 0x83, then 0x80 ×3 → stable unchanged until the third consecutive 0x80, then 4'b0000, `fork_here` = 1, `fork_rise` pulses once.
- Stable left = 0 held; 50 `tick_en` with frames matching → `det_off_long[1]` rises on the 50th tick. `hold_clr` then drops it the next cycle.
- 25 ticks with no frame → `link_ok` = 0, `det_stable` = 4'b1111, `fork_here` = 0. A good frame on the 25th tick's cycle instead keeps `link_ok` = 1.
- 300 frames with header 2'b01 → none accepted, `hdr_err_cnt` = 255.
- `rst` low during a debounce run → all outputs at reset values; the first subsequent good frame loads directly.
